// File: rtl/mark_counter_head_range_pkg.sv
// Shared definitions for the ranged head mark of the ruler search.
// Holds the FSM encoding, default widths and the minimum mark-1 position.
`ifndef MARK_HEAD_MIN_POS
`define MARK_HEAD_MIN_POS 1
`endif

package mark_counter_head_range_pkg;

  localparam int POS_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_LENGTH_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mark_range_cursor.sv
// Cursor for the mark-1 candidate: range latch, load, increment and compare.
// MARK_HEAD_SYMMETRY_EN clamps hi to (MAX_LENGTH-1)/2 at latch time.
import mark_counter_head_range_pkg::*;

module mark_range_cursor #(
  parameter int POS_W      = POS_W_DEF,
  parameter int MAX_LENGTH = MAX_LENGTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [POS_W-1:0] i_range_lo,
  input  logic [POS_W-1:0] i_range_hi,
  output logic [POS_W-1:0] o_cursor,
  output logic             o_at_hi,
  output logic             o_empty
);

`ifdef MARK_HEAD_SYMMETRY_EN
  localparam bit SYM_EN = 1'b1;
`else
  localparam bit SYM_EN = 1'b0;
`endif

  localparam logic [POS_W-1:0] MIN_POS =
    POS_W'(`MARK_HEAD_MIN_POS);
  localparam logic [POS_W-1:0] HALF =
    POS_W'((MAX_LENGTH - 1) / 2);

  logic [POS_W-1:0] r_cursor;
  logic [POS_W-1:0] r_hi;
  logic [POS_W-1:0] w_lo_eff;
  logic [POS_W-1:0] w_hi_eff;

  assign w_lo_eff = (i_range_lo < MIN_POS) ? MIN_POS
                                           : i_range_lo;
  assign w_hi_eff = (SYM_EN && (i_range_hi > HALF)) ? HALF
                                                     : i_range_hi;
  assign o_empty  = (w_lo_eff > w_hi_eff);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cursor <= MIN_POS;
      r_hi     <= MIN_POS;
    end else if (i_load) begin
      r_hi <= w_hi_eff;
      // An empty range leaves the last offered candidate visible.
      if (!o_empty) begin
        r_cursor <= w_lo_eff;
      end
    end else if (i_inc) begin
      r_cursor <= r_cursor + 1'b1;
    end
  end

  assign o_cursor = r_cursor;
  assign o_at_hi  = (r_cursor == r_hi);

endmodule

// File: rtl/mark_counter_head_range.sv
// Head mark (val = 0) sweeping mark-1 candidates over a preset range.
// Optional MARK_HEAD_SYMMETRY_EN prunes mirror-image rulers.
import mark_counter_head_range_pkg::*;

module mark_counter_head_range #(
  parameter int POS_W      = POS_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_LENGTH = MAX_LENGTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [POS_W-1:0] range_lo,
  input  logic [POS_W-1:0] range_hi,
  input  logic             next_ack,
  input  logic             sub_done,
  output logic             ready,
  output logic             busy,
  output logic [POS_W-1:0] val,
  output logic [POS_W-1:0] nextStartValue,
  output logic             next_valid,
  output logic [CNT_W-1:0] issued_count
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_inc;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_at_hi;
  logic             w_empty;
  logic [POS_W-1:0] w_cursor;

  mark_range_cursor #(
    .POS_W      (POS_W),
    .MAX_LENGTH (MAX_LENGTH)
  ) u_cursor (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_inc      (w_inc),
    .i_range_lo (range_lo),
    .i_range_hi (range_hi),
    .o_cursor   (w_cursor),
    .o_at_hi    (w_at_hi),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_load    = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = w_empty ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (next_ack) begin
            w_cnt_inc = 1'b1;
            w_next    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Compare before increment so hi = all-ones never wraps.
          if (sub_done) begin
            if (w_at_hi) begin
              w_next = ST_DONE;
            end else begin
              w_inc  = 1'b1;
              w_next = ST_ISSUE;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign val            = '0;
  assign nextStartValue = w_cursor;
  assign next_valid     = (r_state == ST_ISSUE);
  assign busy           = (r_state == ST_ISSUE) ||
                          (r_state == ST_WAIT);
  assign ready          = (r_state == ST_DONE);
  assign issued_count   = r_cnt;

endmodule

// File: tb/tb_mark_counter_head_range.sv
// Directed bench for mark_counter_head_range (8-bit and 4-bit instances).
// Expectations follow MARK_HEAD_SYMMETRY_EN when it is defined.
module tb_mark_counter_head_range;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, a_abort, a_ack, a_sub;
  logic [7:0]  a_lo, a_hi;
  logic        a_ready, a_busy, a_nv;
  logic [7:0]  a_val, a_nsv;
  logic [15:0] a_cnt;

  logic        b_start, b_abort, b_ack, b_sub;
  logic [3:0]  b_lo, b_hi;
  logic        b_ready, b_busy, b_nv;
  logic [3:0]  b_val, b_nsv;
  logic [15:0] b_cnt;

  int checks   = 0;
  int failures = 0;
  bit sel4     = 1'b0;

  mark_counter_head_range #(
    .POS_W(8), .CNT_W(16), .MAX_LENGTH(17)
  ) u_a (
    .clock(clk), .reset(rst_n),
    .start(a_start), .abort(a_abort),
    .range_lo(a_lo), .range_hi(a_hi),
    .next_ack(a_ack), .sub_done(a_sub),
    .ready(a_ready), .busy(a_busy), .val(a_val),
    .nextStartValue(a_nsv), .next_valid(a_nv),
    .issued_count(a_cnt)
  );

  mark_counter_head_range #(
    .POS_W(4), .CNT_W(16), .MAX_LENGTH(15)
  ) u_b (
    .clock(clk), .reset(rst_n),
    .start(b_start), .abort(b_abort),
    .range_lo(b_lo), .range_hi(b_hi),
    .next_ack(b_ack), .sub_done(b_sub),
    .ready(b_ready), .busy(b_busy), .val(b_val),
    .nextStartValue(b_nsv), .next_valid(b_nv),
    .issued_count(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic ack,
                     input logic sub, input logic ab,
                     input int lo, input int hi);
    a_start = st & ~sel4;  b_start = st & sel4;
    a_ack   = ack & ~sel4; b_ack   = ack & sel4;
    a_sub   = sub & ~sel4; b_sub   = sub & sel4;
    a_abort = ab & ~sel4;  b_abort = ab & sel4;
    if (sel4) begin
      b_lo = lo[3:0]; b_hi = hi[3:0];
    end else begin
      a_lo = lo[7:0]; a_hi = hi[7:0];
    end
  endtask

  function automatic logic [31:0] nv();
    return sel4 ? 32'(b_nv) : 32'(a_nv);
  endfunction
  function automatic logic [31:0] nsv();
    return sel4 ? 32'(b_nsv) : 32'(a_nsv);
  endfunction
  function automatic logic [31:0] rdy();
    return sel4 ? 32'(b_ready) : 32'(a_ready);
  endfunction
  function automatic logic [31:0] cnt();
    return sel4 ? 32'(b_cnt) : 32'(a_cnt);
  endfunction

  // Offers expected first..last; first > last means empty range.
  task automatic sweep(input string nm, input int lo,
                       input int hi, input int first,
                       input int last);
    drv(1, 0, 0, 0, lo, hi);
    step();
    drv(0, 0, 0, 0, 99, 99);
    if (first > last) begin
      chk({nm, "_empty_ready"}, rdy(), 1);
      chk({nm, "_empty_nv"}, nv(), 0);
      chk({nm, "_empty_cnt"}, cnt(), 0);
      return;
    end
    for (int v = first; v <= last; v++) begin
      chk({nm, "_offer_nv"}, nv(), 1);
      chk({nm, "_offer_val"}, nsv(), v);
      chk({nm, "_offer_rdy"}, rdy(), 0);
      drv(0, 1, 0, 0, 99, 99);
      step();
      drv(0, 0, 0, 0, 99, 99);
      chk({nm, "_wait_nv"}, nv(), 0);
      step();
      step();
      drv(0, 0, 1, 0, 99, 99);
      step();
      drv(0, 0, 0, 0, 99, 99);
    end
    chk({nm, "_done_ready"}, rdy(), 1);
    chk({nm, "_done_nv"}, nv(), 0);
    chk({nm, "_done_cnt"}, cnt(), last - first + 1);
    chk({nm, "_done_last"}, nsv(), last);
  endtask

  initial begin
    rst_n = 1'b0;
    sel4 = 1'b1; drv(0, 0, 0, 0, 0, 0);
    sel4 = 1'b0; drv(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: reset state
    chk("rst_val", 32'(a_val), 0);
    chk("rst_nsv", 32'(a_nsv), 1);
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_nv", 32'(a_nv), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_b_nsv", 32'(b_nsv), 1);

    // 2: basic sweep 2..4
    sweep("t2", 2, 4, 2, 4);

    // 3: lo=0, hi=0 is empty after clamping lo to 1
    sweep("t3", 0, 0, 1, 0);
    chk("t3_hold_last", 32'(a_nsv), 4);

    // 4: ack stall, then abort in WAIT
    drv(1, 0, 0, 0, 3, 9);
    step();
    drv(0, 0, 0, 0, 200, 1);
    chk("t4_ready_drop", 32'(a_ready), 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_nv", 32'(a_nv), 1);
      chk("t4_stall_val", 32'(a_nsv), 3);
      step();
    end
    chk("t4_stall_cnt", 32'(a_cnt), 0);
    drv(0, 1, 0, 0, 200, 1);
    step();
    drv(0, 0, 0, 0, 200, 1);
    chk("t4_wait_busy", 32'(a_busy), 1);
    chk("t4_wait_cnt", 32'(a_cnt), 1);
    drv(0, 0, 0, 1, 200, 1);
    step();
    drv(0, 0, 0, 0, 200, 1);
    chk("t4_abort_ready", 32'(a_ready), 0);
    chk("t4_abort_busy", 32'(a_busy), 0);
    chk("t4_abort_nv", 32'(a_nv), 0);
    chk("t4_abort_cnt", 32'(a_cnt), 1);

    // abort beats start in the same cycle
    drv(1, 0, 0, 1, 2, 4);
    step();
    drv(0, 0, 0, 0, 2, 4);
    chk("abort_wins_busy", 32'(a_busy), 0);
    chk("abort_wins_cnt", 32'(a_cnt), 1);

    // 5: 4-bit top of range, no wrap
    sel4 = 1'b1;
`ifdef MARK_HEAD_SYMMETRY_EN
    sweep("t5", 14, 15, 14, 7);
`else
    sweep("t5", 14, 15, 14, 15);
    step();
    chk("t5_no_wrap_nv", 32'(b_nv), 0);
    chk("t5_no_wrap_val", 32'(b_nsv), 15);
`endif

    // 6: symmetry clamp with MAX_LENGTH = 17
    sel4 = 1'b0;
`ifdef MARK_HEAD_SYMMETRY_EN
    sweep("t6", 1, 15, 1, 8);
`else
    sweep("t6", 1, 15, 1, 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mark_counter_head_range.md
Name: mark_counter_head_range

Overview:
- Parametrised successor of the fixed head mark. Still owns mark 0 (val = 0), but actively sweeps the candidate position of the first downstream mark over an externally preset range [range_lo, range_hi].
- Hands each candidate to the downstream mark chain with a valid/ack handshake. Waits for that subtree to report exhaustion, then advances.
- Lets a host split one ruler search into disjoint ranges across several instances or boards. ready asserts when the assigned range is finished.

Parameters:
- POS_W, 8, position value width in bits; replaces the fixed `PositionValueBitMax+1.
- CNT_W, 16, width of the issued-candidate counter.
- MAX_LENGTH, 255, ruler length bound used by the optional symmetry pruning; must be < 2^POS_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches range and begins sweep; honoured only in IDLE or DONE.
- abort  in  1  synchronous; returns to IDLE from any state.
- range_lo  in  POS_W  first candidate for mark 1.
- range_hi  in  POS_W  last candidate for mark 1, inclusive.
- next_ack  in  1  downstream accepted nextStartValue.
- sub_done  in  1  downstream subtree for current candidate exhausted; one-cycle pulse.
- ready  out  1  range completely swept; high only in DONE.
- busy  out  1  high in ISSUE or WAIT.
- val  out  POS_W  constant 0; this mark is always at position 0.
- nextStartValue  out  POS_W  current candidate for mark 1.
- next_valid  out  1  candidate offered to downstream.
- issued_count  out  CNT_W  number of candidates accepted since last start.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE
  - ready = 0, busy = 0, next_valid = 0
  - nextStartValue = 1, issued_count = 0
  - val = 0 at all times.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE / DONE + start:
  - Latch lo_eff = max(range_lo, 1) and hi = range_hi.
  - Clear issued_count.
  - If lo_eff > hi, go to DONE next cycle with ready = 1; the empty range is not an error.
  - Otherwise set cursor = lo_eff and go to ISSUE.
- ISSUE:
  - next_valid = 1, nextStartValue = cursor.
  - Output holds stable until next_ack.
  - On next_ack: issued_count += 1 (saturating at all-ones), go to WAIT.
  - sub_done in ISSUE is ignored.
- WAIT:
  - next_valid = 0.
  - On sub_done with cursor == hi: go to DONE.
  - On sub_done with cursor != hi: cursor += 1, go to ISSUE.
  - Compare precedes increment, so hi = 2^POS_W-1 never wraps to 0.
- DONE:
  - ready = 1 and nextStartValue holds the last candidate until start or abort.
  - start in DONE restarts immediately; ready drops the cycle after start.
- abort:
  - Wins over every other input in the same cycle, including start.
  - Next state IDLE, next_valid = 0, ready = 0; issued_count is retained.
- start while busy is ignored. Ranges are latched, so range inputs may change freely after start.
- Latency:
  - start to first next_valid: 1 cycle.
  - sub_done to next next_valid: 1 cycle.
  - sub_done on hi to ready: 1 cycle.
- Async reset mid-sweep discards all progress; no partial-result reporting.

Optional Feature:
- Macro MARK_HEAD_SYMMETRY_EN.
- Defined: effective hi = min(range_hi, (MAX_LENGTH-1)/2), using integer division.
  - This prunes mirror-image rulers: mark 1 beyond the half length duplicates a reversed ruler.
  - Clamping happens at latch time. An empty result goes straight to DONE.
- Undefined: range_hi is used unchanged and MAX_LENGTH is unused.

Decomposition:
- Shared package/include (extending definitions.v):
  - state encodings for IDLE, ISSUE, WAIT, DONE;
  - default POS_W;
  - a macro for the minimum legal mark-1 position (1).
- Natural sub-module: mark_range_cursor.
  - Holds the cursor register, load, increment and compare-to-hi.
  - Produces at_hi and empty flags.
  - The FSM wraps it.

Test Plan:
1. Reset low then high, no start → val = 0, nextStartValue = 1, ready = 0, next_valid = 0, issued_count = 0.
2. start, lo = 2, hi = 4; ack each issue, sub_done 3 cycles after each ack.
   - Offered values are 2, 3, 4; ready rises 1 cycle after the third sub_done; issued_count = 3.
3. start, lo = 0, hi = 0 → lo_eff = 1 > 0 → ready = 1 the next cycle, no next_valid ever.
4. start, lo = 3, hi = 9; next_ack held low 5 cycles → next_valid and nextStartValue = 3 stable throughout. Then abort during WAIT → IDLE next cycle, ready = 0, issued_count = 1.
5. POS_W = 4, lo = 14, hi = 15 → offers 14 then 15, then DONE with no wrap to 0.
6. With MARK_HEAD_SYMMETRY_EN, MAX_LENGTH = 17, lo = 1, hi = 15 → offers 1..8 only, then ready. Without the macro → offers 1..15.
